// File: rtl/switch_debouncer_if.sv
// -----------------------------------------------------------------------------
// switch_debouncer_if
//   Groups the switch-side signals of the debouncer.
//   raw_in : asynchronous switch pin (driven by the pin / stimulus side)
//   level  : debounced, registered level
//   rise   : one-cycle pulse in the cycle level goes 0->1
//   fall   : one-cycle pulse in the cycle level goes 1->0
//   busy   : 1 while a candidate transition is being timed
//   modport master : the side that drives the pin and consumes the results
//   modport slave  : the debouncer itself
// -----------------------------------------------------------------------------
interface switch_debouncer_if;
  logic raw_in;
  logic level;
  logic rise;
  logic fall;
  logic busy;

  modport master (output raw_in, input level, input rise, input fall, input busy);
  modport slave  (input raw_in, output level, output rise, output fall, output busy);
endinterface

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//   Turns one raw, bouncing switch pin into a clean synchronous level plus
//   one-cycle rise/fall strobes. The level feeds the sequence-detecting FSM.
//   A new input value is accepted only after the synchronised input has held
//   it for DEBOUNCE_CYCLES+1 consecutive samples; any bounce restarts timing.
// Parameters
//   SYNC_STAGES     : synchroniser depth on raw_in (>= 2)
//   DEBOUNCE_CYCLES : stability window in clock cycles (>= 2)
// Ports
//   clock     : system clock, all logic on posedge
//   reset     : synchronous, active-high
//   sw.raw_in : asynchronous switch pin
//   sw.level  : debounced level (registered)
//   sw.rise   : one-cycle pulse with level 0->1 (registered)
//   sw.fall   : one-cycle pulse with level 1->0 (registered)
//   sw.busy   : 1 while a candidate transition is being timed (registered)
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clock,
  input  logic              reset,
  switch_debouncer_if.slave sw
);

  // Derived counter width; it only has to hold DEBOUNCE_CYCLES-1.
  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b10,
    PEND_LO   = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;

  // ---------------------------------------------------------------------------
  // Synchroniser: only the last stage is ever looked at by the FSM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw.raw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // State register (together with counter and registered outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The counter restarts at 0 on every PEND entry and stops
  // at CNT_LAST, where the transition is taken instead of incrementing, so it
  // can never wrap. In STABLE_* states it simply holds.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = PEND_HI;
          cnt_d   = '0;
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = PEND_LO;
          cnt_d   = '0;
        end
      end
      PEND_LO: begin
        if (s) begin
          state_d = STABLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. Outputs are computed from the upcoming state so that the
  // registered versions line up with the state register: level and the
  // strobe change on the same edge that completes the window. A rejected
  // glitch (PEND_* back to its STABLE_*) leaves level untouched.
  // ---------------------------------------------------------------------------
  always_comb begin
    level_d = (state_d == STABLE_HI) || (state_d == PEND_LO);
    busy_d  = (state_d == PEND_HI)   || (state_d == PEND_LO);
    rise_d  = (state_q == PEND_HI)   && (state_d == STABLE_HI);
    fall_d  = (state_q == PEND_LO)   && (state_d == STABLE_LO);
  end

  assign sw.level = level_q;
  assign sw.rise  = rise_q;
  assign sw.fall  = fall_q;
  assign sw.busy  = busy_q;

endmodule
